// File: rtl/note_player.sv
// Note sequencer: fetches 8-bit note words from an upstream ROM and plays each as a square-wave tone.
// Define NOTE_PLAYER_GAP_EN to silence the last GAP_CYCLES cycles of every note.
module note_player #(
    parameter int unsigned BEAT_CYCLES = 12500000
`ifdef NOTE_PLAYER_GAP_EN
    , parameter int unsigned GAP_CYCLES = 625000
`endif
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       play,
    input  logic       loop,
    input  logic [7:0] note_data,
    input  logic       music_finish,
    output logic       addr_en,
    output logic       buzzer,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_ADV} state_t;

    localparam logic [23:0] BEAT_LAST = 24'(BEAT_CYCLES - 1);
`ifdef NOTE_PLAYER_GAP_EN
    localparam logic [23:0] GAP_START = 24'(BEAT_CYCLES - GAP_CYCLES);
`endif

    state_t      state_q, state_d;
    logic        fetch_cnt_q, fetch_cnt_d;
    logic [7:0]  note_q, note_d;
    logic [23:0] beat_cnt_q, beat_cnt_d;
    logic [3:0]  beat_idx_q, beat_idx_d;
    logic [16:0] tone_cnt_q, tone_cnt_d;
    logic        buzz_q, buzz_d;
    logic        done_q, done_d;
    logic [16:0] half_period;
    logic        last_cycle;
    logic        in_gap;

    // Half-periods of the C4..C6 major scale at a 50 MHz clock.
    function automatic logic [16:0] half_period_of(input logic [3:0] pitch);
        case (pitch)
            4'd1:    return 17'd95556;
            4'd2:    return 17'd85131;
            4'd3:    return 17'd75843;
            4'd4:    return 17'd71586;
            4'd5:    return 17'd63776;
            4'd6:    return 17'd56818;
            4'd7:    return 17'd50619;
            4'd8:    return 17'd47778;
            4'd9:    return 17'd42566;
            4'd10:   return 17'd37921;
            4'd11:   return 17'd35793;
            4'd12:   return 17'd31888;
            4'd13:   return 17'd28409;
            4'd14:   return 17'd25310;
            4'd15:   return 17'd23889;
            default: return 17'd0;
        endcase
    endfunction

    assign half_period = half_period_of(note_q[7:4]);
    assign last_cycle  = (beat_cnt_q == BEAT_LAST) && (beat_idx_q == note_q[3:0]);

`ifdef NOTE_PLAYER_GAP_EN
    assign in_gap = (beat_idx_q == note_q[3:0]) && (beat_cnt_q >= GAP_START);
`else
    assign in_gap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            fetch_cnt_q <= 1'b0;
            note_q      <= 8'd0;
            beat_cnt_q  <= 24'd0;
            beat_idx_q  <= 4'd0;
            tone_cnt_q  <= 17'd0;
            buzz_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            note_q      <= note_d;
            beat_cnt_q  <= beat_cnt_d;
            beat_idx_q  <= beat_idx_d;
            tone_cnt_q  <= tone_cnt_d;
            buzz_q      <= buzz_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        note_d      = note_q;
        beat_cnt_d  = beat_cnt_q;
        beat_idx_d  = beat_idx_q;
        tone_cnt_d  = tone_cnt_q;
        buzz_d      = buzz_q;
        done_d      = 1'b0;

        // Dropping play wins over everything, including a same-edge end of song.
        if (!play) begin
            state_d     = S_IDLE;
            fetch_cnt_d = 1'b0;
            beat_cnt_d  = 24'd0;
            beat_idx_d  = 4'd0;
            tone_cnt_d  = 17'd0;
            buzz_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d     = S_FETCH;
                    fetch_cnt_d = 1'b0;
                end
                S_FETCH: begin
                    if (!fetch_cnt_q) begin
                        fetch_cnt_d = 1'b1;
                    end else begin
                        fetch_cnt_d = 1'b0;
                        note_d      = note_data;
                        beat_cnt_d  = 24'd0;
                        beat_idx_d  = 4'd0;
                        tone_cnt_d  = 17'd0;
                        buzz_d      = 1'b0;
                        state_d     = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if ((note_q[7:4] != 4'd0) && !in_gap) begin
                        if (tone_cnt_q == half_period - 17'd1) begin
                            tone_cnt_d = 17'd0;
                            buzz_d     = ~buzz_q;
                        end else begin
                            tone_cnt_d = tone_cnt_q + 17'd1;
                        end
                    end
                    if (beat_cnt_q == BEAT_LAST) begin
                        beat_cnt_d = 24'd0;
                        beat_idx_d = beat_idx_q + 4'd1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 24'd1;
                    end
                    if (last_cycle) begin
                        beat_cnt_d = 24'd0;
                        beat_idx_d = 4'd0;
                        tone_cnt_d = 17'd0;
                        buzz_d     = 1'b0;
                        if (music_finish && !loop) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ADV;
                        end
                    end
                end
                S_ADV: begin
                    state_d = S_FETCH;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign addr_en = (state_q == S_ADV);
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign buzzer  = buzz_q & ~(in_gap && (state_q == S_PLAY));

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: cycle-by-cycle comparison against a timeline model built from note lengths and tone periods.
module tb_note_player;

    localparam int BEAT = 1500;
`ifdef NOTE_PLAYER_GAP_EN
    localparam int GAP = 50;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       play;
    logic       loop;
    logic [7:0] note_data;
    logic       music_finish;
    logic       addr_en;
    logic       buzzer;
    logic       busy;
    logic       done;

    logic [7:0] rom [4];
    logic [1:0] addr;
    logic [1:0] last_addr;
    int         n_cmp = 0;
    int         n_mis = 0;
    int         half_tbl [16] = '{0, 95556, 85131, 75843, 71586, 63776, 56818, 50619,
                                  47778, 42566, 37921, 35793, 31888, 28409, 25310, 23889};

    note_player #(
        .BEAT_CYCLES(BEAT)
`ifdef NOTE_PLAYER_GAP_EN
        , .GAP_CYCLES(GAP)
`endif
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .play        (play),
        .loop        (loop),
        .note_data   (note_data),
        .music_finish(music_finish),
        .addr_en     (addr_en),
        .buzzer      (buzzer),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Upstream address counter and ROM.
    assign note_data    = rom[addr];
    assign music_finish = (addr == last_addr);
    always @(posedge clk or negedge rstn) begin
        if (!rstn)        addr <= 2'd0;
        else if (addr_en) addr <= (addr == last_addr) ? 2'd0 : addr + 2'd1;
    end

    task automatic report();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    endtask

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: busy/addr_en/done/buzzer got %b want %b", tag, $time, got, exp);
            if (n_mis >= 25) report();
        end
    endtask

    task automatic step(input bit b, input bit a, input bit d, input bit z, input string tag);
        @(negedge clk);
        check_eq(tag, {busy, addr_en, done, buzzer}, {b, a, d, z});
    endtask

    // Buzzer level t cycles into a note of length dur: high during odd half-periods.
    function automatic bit exp_buzz(input logic [3:0] pitch, input int t, input int dur);
        if (pitch == 4'd0) return 1'b0;
`ifdef NOTE_PLAYER_GAP_EN
        if (t >= dur - GAP) return 1'b0;
`else
        if (dur < 0) return 1'b0;
`endif
        return ((t / half_tbl[pitch]) % 2) == 1;
    endfunction

    // Plays one note starting with its first FETCH cycle. Position p counts 0,1 = FETCH,
    // 2..dur+1 = PLAY, dur+2 = ADV. oc: 0 advanced, 1 done, 2 aborted, 3 aborted after ADV.
    task automatic model_note(input logic [7:0] nd, input bit fin, input int abort_p,
                              input bit use_rst, output int oc);
        int dur;
        dur = (int'(nd[3:0]) + 1) * BEAT;
        for (int p = 0; p < dur + 2; p++) begin
            if (p < 2) step(1'b1, 1'b0, 1'b0, 1'b0, "fetch");
            else       step(1'b1, 1'b0, 1'b0, exp_buzz(nd[7:4], p - 2, dur), "play");
            if (p == abort_p) begin
                if (use_rst) begin
                    #2 rstn = 1'b0;
                    #1 check_eq("rst_async", {busy, addr_en, done, buzzer}, 4'b0000);
                    step(1'b0, 1'b0, 1'b0, 1'b0, "rst_hold");
                    rstn = 1'b1;
                end else begin
                    play = 1'b0;
                    step(1'b0, 1'b0, 1'b0, 1'b0, "abort");
                end
                oc = 2;
                return;
            end
        end
        if (fin && !loop) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, "done");
            oc = 1;
        end else begin
            step(1'b1, 1'b1, 1'b0, 1'b0, "adv");
            oc = 0;
            if (abort_p == dur + 2) begin
                play = 1'b0;
                step(1'b0, 1'b0, 1'b0, 1'b0, "abort_adv");
                oc = 3;
            end
        end
    endtask

    task automatic pulse_reset();
        play = 1'b0;
        rstn = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, "rst");
        rstn = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    endtask

    initial begin
        int oc;
        int idx;
        int ab;
        logic [7:0] nd;
        rstn = 1'b0;
        play = 1'b0;
        loop = 1'b0;
        last_addr = 2'd0;
        for (int i = 0; i < 4; i++) rom[i] = 8'h00;

        // Reset state, including play high while reset is held.
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, "reset");
        play = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, "reset_play");
        play = 1'b0;
        rstn = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, "idle");

        // Longest top-pitch note to done, restart from the same address, reset mid-tone.
        rom[0] = 8'hFF;
        play = 1'b1;
        model_note(8'hFF, 1'b1, -1, 1'b0, oc);
        model_note(8'hFF, 1'b1, 23922, 1'b1, oc);
        play = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, "idle_after_rst");

        // Two-note sequence: rest of two beats, then one beat, then done.
        pulse_reset();
        rom[0] = 8'h01;
        rom[1] = 8'h00;
        last_addr = 2'd1;
        play = 1'b1;
        model_note(8'h01, 1'b0, -1, 1'b0, oc);
        model_note(8'h00, 1'b1, -1, 1'b0, oc);
        play = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, "idle_seq");

        // Loop on a single-entry song, then drop play during FETCH.
        pulse_reset();
        rom[0] = 8'h30;
        last_addr = 2'd0;
        loop = 1'b1;
        play = 1'b1;
        repeat (4) model_note(8'h30, 1'b1, -1, 1'b0, oc);
        model_note(8'h30, 1'b1, 1, 1'b0, oc);
        loop = 1'b0;

        // Abort mid-note, then abort on the last PLAY cycle while music_finish is high.
        pulse_reset();
        rom[0] = 8'h63;
        play = 1'b1;
        model_note(8'h63, 1'b1, int'($urandom_range(2, 6001)), 1'b0, oc);
        rom[0] = 8'h61;
        play = 1'b1;
        model_note(8'h61, 1'b1, 3001, 1'b0, oc);
        step(1'b0, 1'b0, 1'b0, 1'b0, "idle_abort");

        // Randomised songs with occasional aborts.
        for (int s = 0; s < 2; s++) begin
            pulse_reset();
            for (int i = 0; i < 4; i++) rom[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 1))};
            last_addr = 2'($urandom_range(0, 3));
            loop = 1'($urandom_range(0, 1));
            idx = 0;
            play = 1'b1;
            for (int n = 0; n < 4; n++) begin
                nd = rom[idx];
                ab = ($urandom_range(0, 4) == 0) ?
                     int'($urandom_range(0, (int'(nd[3:0]) + 1) * BEAT + 2)) : -1;
                model_note(nd, idx == int'(last_addr), ab, 1'b0, oc);
                if (oc == 0 || oc == 3) idx = (idx == int'(last_addr)) ? 0 : idx + 1;
                play = 1'b1;
            end
            play = 1'b0;
            step(1'b0, 1'b0, 1'b0, 1'b0, "idle_rand");
            loop = 1'b0;
        end

        report();
    end

endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 Parameter BEAT_CYCLES, 12500000: clock cycles per beat, 24-bit, at least 4.
REQ-002 Parameter GAP_CYCLES, 625000: silent cycles at each note end, gap build only, less than BEAT_CYCLES.
REQ-003 Port clk, input, 1: single clock.
REQ-004 Port rstn, input, 1: asynchronous active-low reset.
REQ-005 Port play, input, 1: level run enable.
REQ-006 Port loop, input, 1: replay the note range after its last note.
REQ-007 Port note_data, input, 8: ROM word at the current address; [7:4] pitch index, 0 = rest; [3:0] length, played as length+1 beats.
REQ-008 Port music_finish, input, 1: current address equals the final address.
REQ-009 Port addr_en, output, 1: one-cycle pulse that advances the upstream address counter.
REQ-010 Port buzzer, output, 1: square-wave tone.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port done, output, 1: one-cycle pulse at non-loop end of song.

Function
REQ-013 States SHALL be IDLE, FETCH, PLAY and ADV, in a registered FSM.
REQ-014 IDLE SHALL go to FETCH on the first clock edge that samples play=1.
REQ-015 FETCH SHALL last exactly 2 cycles, covering address update and synchronous ROM latency.
REQ-016 At the final FETCH edge, the block SHALL latch note_data into note_reg, clear all counters, set buzzer=0 and enter PLAY.
REQ-017 PLAY SHALL last exactly (note_reg[3:0]+1)*BEAT_CYCLES cycles.
- Beat counter: 24-bit, 0..BEAT_CYCLES-1.
- Beat index: 4-bit, 0..note_reg[3:0].
REQ-018 During PLAY with pitch index 1..15, buzzer SHALL toggle each time the 17-bit tone counter reaches half_period-1; the tone counter then returns to 0.
REQ-019 half_period for pitch index 1..15 (C4..C6 major scale at 50 MHz) SHALL be:
- 95556, 85131, 75843, 71586, 63776
- 56818, 50619, 47778, 42566, 37921
- 35793, 31888, 28409, 25310, 23889
REQ-020 Pitch index 0 (rest) SHALL hold buzzer=0 and the tone counter at 0 for the whole duration.
REQ-021 On the last PLAY cycle, the block SHALL sample music_finish:
- music_finish=1 and loop=0: go to IDLE, pulse done for 1 cycle, issue no addr_en.
- Otherwise: go to ADV.
REQ-022 ADV SHALL last 1 cycle with addr_en=1, then go to FETCH.
- Note-to-note overhead is exactly 3 cycles.
- A looping wrap is performed by the upstream counter, not by this block.
REQ-023 addr_en SHALL be high only in ADV, never for 2 consecutive cycles.
REQ-024 play=0 sampled in any state SHALL force IDLE on that edge.
- buzzer=0 and all counters cleared.
- No addr_en and no done.
REQ-025 play=0 and music_finish=1 on the same edge SHALL give the play=0 behaviour only.
REQ-026 play held high after done SHALL restart the sequence (IDLE then FETCH on the next edge) from the current address.

Reset
REQ-027 rstn low SHALL asynchronously force the following, held until rstn rises:
- State IDLE.
- note_reg=0 and all counters 0.
- buzzer=0, addr_en=0, busy=0, done=0.
REQ-028 Reset asserted mid-note SHALL drop busy and buzzer immediately without waiting for a clock edge.

Configuration
REQ-029 Macro NOTE_PLAYER_GAP_EN defined: during the final GAP_CYCLES cycles of each PLAY, buzzer SHALL be held 0 and the tone counter frozen; total note duration is unchanged.
REQ-030 Macro NOTE_PLAYER_GAP_EN undefined: tone SHALL continue for the full PLAY duration; GAP_CYCLES and its logic are absent.

Verification (BEAT_CYCLES=100000, GAP_CYCLES=10000 unless stated)
REQ-031 Single note: note_data=0xF0, music_finish=1, loop=0, play rises.
- busy rises 1 cycle after play sampled.
- buzzer first toggles 23889 cycles into PLAY.
- done pulses after exactly 100000 PLAY cycles.
- addr_en never asserts.
REQ-032 Sequence: note_data=0x01 then 0x00, music_finish=1 on the second note.
- First PLAY lasts 200000 cycles with buzzer constantly 0.
- One addr_en pulse follows.
- Second note starts 3 cycles after the first ends.
- done pulses after the second note.
REQ-033 Loop: loop=1, music_finish=1 on every note.
- addr_en pulses every BEAT_CYCLES+3 cycles indefinitely.
- done stays 0.
REQ-034 Abort: play drops mid-PLAY of note 0x63.
- Next edge: state IDLE, buzzer 0, busy 0.
- No addr_en and no done.
- Same result when rstn is asserted instead, taking effect asynchronously.
REQ-035 Gap build: note_data=0xF0 with NOTE_PLAYER_GAP_EN defined.
- buzzer SHALL be 0 from PLAY cycle 90000 to 99999.
- done timing is identical to REQ-031.
